// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_read_arbiter
// Purpose  : Shares one AXI4 read channel (AR/R) between the instruction
//            fetch requester (IF, id 0) and the data memory requester
//            (DM, id 1). One burst is outstanding at a time. The winner is
//            tagged onto ARID, its R beats are routed back to it, and the
//            burst framing is checked beat by beat.
// Ports    : clk_i, reset_i          clock / synchronous active-low reset
//            <r>_req_*               burst request (valid/ready/addr/len/burst)
//            <r>_resp_*              returned beats (valid/ready/data/last/err)
//            m_axi_ar*               AXI4 read address channel (master side)
//            m_axi_r*                AXI4 read data channel (master side)
//            proto_err_o             sticky framing / RID error flag
//            <r> is "if" (instruction fetch) or "dm" (data memory).
// Revision : 1.0 - initial release
// ============================================================================
module axi_read_arbiter #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_i,

  // Instruction fetch requester
  input  logic                  if_req_valid_i,
  output logic                  if_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] if_req_addr_i,
  input  logic [7:0]            if_req_len_i,
  input  logic [1:0]            if_req_burst_i,
  output logic                  if_resp_valid_o,
  input  logic                  if_resp_ready_i,
  output logic [DATA_WIDTH-1:0] if_resp_data_o,
  output logic                  if_resp_last_o,
  output logic                  if_resp_err_o,

  // Data memory requester
  input  logic                  dm_req_valid_i,
  output logic                  dm_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] dm_req_addr_i,
  input  logic [7:0]            dm_req_len_i,
  input  logic [1:0]            dm_req_burst_i,
  output logic                  dm_resp_valid_o,
  input  logic                  dm_resp_ready_i,
  output logic [DATA_WIDTH-1:0] dm_resp_data_o,
  output logic                  dm_resp_last_o,
  output logic                  dm_resp_err_o,

  // AXI4 read address channel
  output logic [ID_WIDTH-1:0]   m_axi_arid_o,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr_o,
  output logic [7:0]            m_axi_arlen_o,
  output logic [2:0]            m_axi_arsize_o,
  output logic [1:0]            m_axi_arburst_o,
  output logic                  m_axi_arlock_o,
  output logic [3:0]            m_axi_arcache_o,
  output logic [2:0]            m_axi_arprot_o,
  output logic                  m_axi_arvalid_o,
  input  logic                  m_axi_arready_i,

  // AXI4 read data channel
  input  logic [ID_WIDTH-1:0]   m_axi_rid_i,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata_i,
  input  logic [1:0]            m_axi_rresp_i,
  input  logic                  m_axi_rlast_i,
  input  logic                  m_axi_rvalid_i,
  output logic                  m_axi_rready_o,

  output logic                  proto_err_o
);

  localparam logic       REQ_IF       = 1'b0;
  localparam logic       REQ_DM       = 1'b1;
  localparam logic [2:0] C_ARSIZE     = 3'b011;   // 8-byte beats
  localparam logic [3:0] C_ARCACHE    = 4'b0011;  // normal, non-cacheable, bufferable
  localparam logic [2:0] C_ARPROT_IF  = 3'b100;   // instruction access
  localparam logic [2:0] C_ARPROT_DM  = 3'b000;   // data access

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  state_e                state_q,      state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  winner_q,     winner_d;
  logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic [7:0]            len_q,        len_d;
  logic [1:0]            burst_q,      burst_d;
  logic [7:0]            beat_cnt_q,   beat_cnt_d;
  logic                  proto_err_q,  proto_err_d;

  logic                  any_req;
  logic                  grant;
  logic [ID_WIDTH-1:0]   exp_id;
  logic                  rready;
  logic                  beat_hs;
  logic                  rid_bad;
  logic                  last_bad;
  logic                  beat_err;
  logic                  beat_valid;

  // Round robin: on a tie the requester that did not finish the previous
  // burst wins; a lone requester always wins.
  assign any_req = if_req_valid_i | dm_req_valid_i;
  assign grant   = (if_req_valid_i && dm_req_valid_i) ? ~last_grant_q : dm_req_valid_i;

  assign exp_id  = {{(ID_WIDTH-1){1'b0}}, winner_q};

  // R channel is only ever opened in DATA, so no beat can slip in elsewhere.
  assign rready     = (state_q == S_DATA) &&
                      ((winner_q == REQ_DM) ? dm_resp_ready_i : if_resp_ready_i);
  assign beat_valid = (state_q == S_DATA) && m_axi_rvalid_i;
  assign beat_hs    = beat_valid && rready;

  // Framing: RLAST must be asserted exactly on beat index len. An early
  // RLAST and a missing RLAST both show up as a mismatch here.
  assign rid_bad  = (m_axi_rid_i != exp_id);
  assign last_bad = (m_axi_rlast_i != (beat_cnt_q == len_q));
  assign beat_err = (m_axi_rresp_i != 2'b00) || rid_bad || last_bad;

  // AR channel is driven purely from latched state, so it stays stable
  // for as long as ADDR waits on arready.
  assign m_axi_arvalid_o = (state_q == S_ADDR);
  assign m_axi_arid_o    = exp_id;
  assign m_axi_araddr_o  = addr_q;
  assign m_axi_arlen_o   = len_q;
  assign m_axi_arburst_o = burst_q;
  assign m_axi_arsize_o  = C_ARSIZE;
  assign m_axi_arlock_o  = 1'b0;
  assign m_axi_arcache_o = C_ARCACHE;
  assign m_axi_arprot_o  = (winner_q == REQ_IF) ? C_ARPROT_IF : C_ARPROT_DM;

  assign m_axi_rready_o  = rready;

  // Data and last are broadcast; only resp_valid qualifies them.
  assign if_resp_data_o  = m_axi_rdata_i;
  assign dm_resp_data_o  = m_axi_rdata_i;
  assign if_resp_last_o  = m_axi_rlast_i;
  assign dm_resp_last_o  = m_axi_rlast_i;

  assign if_resp_valid_o = beat_valid && (winner_q == REQ_IF);
  assign dm_resp_valid_o = beat_valid && (winner_q == REQ_DM);
  assign if_resp_err_o   = if_resp_valid_o && beat_err;
  assign dm_resp_err_o   = dm_resp_valid_o && beat_err;

  assign proto_err_o     = proto_err_q;

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    winner_d       = winner_q;
    addr_d         = addr_q;
    len_d          = len_q;
    burst_d        = burst_q;
    beat_cnt_d     = beat_cnt_q;
    proto_err_d    = proto_err_q;
    if_req_ready_o = 1'b0;
    dm_req_ready_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          winner_d = grant;
          if (grant == REQ_DM) begin
            addr_d         = dm_req_addr_i;
            len_d          = dm_req_len_i;
            burst_d        = dm_req_burst_i;
            dm_req_ready_o = 1'b1;
          end else begin
            addr_d         = if_req_addr_i;
            len_d          = if_req_len_i;
            burst_d        = if_req_burst_i;
            if_req_ready_o = 1'b1;
          end
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        if (m_axi_arready_i) begin
          beat_cnt_d = 8'd0;
          state_d    = S_DATA;
        end
      end

      S_DATA: begin
        if (beat_hs) begin
          // 8-bit counter wraps naturally after the 256th beat of len=255.
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (rid_bad || last_bad) begin
            proto_err_d = 1'b1;
          end
          // RLAST closes the burst even if it arrives early; after a
          // missing RLAST we simply keep accepting beats until it shows up.
          if (m_axi_rlast_i) begin
            last_grant_d = winner_q;
            state_d      = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // No grant may be signalled while the block is being held in reset.
    if (!reset_i) begin
      if_req_ready_o = 1'b0;
      dm_req_ready_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q      <= S_IDLE;
      last_grant_q <= REQ_DM;  // IF wins the first tie after reset
      winner_q     <= REQ_IF;
      addr_q       <= '0;
      len_q        <= 8'd0;
      burst_q      <= 2'b00;
      beat_cnt_q   <= 8'd0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      burst_q      <= burst_d;
      beat_cnt_q   <= beat_cnt_d;
      proto_err_q  <= proto_err_d;
    end
  end

endmodule
`default_nettype wire
